// File: rtl/half_adder_self_checker_if.sv
// Operand/result bus between the self-checker and the half adder under test.
// The checker is the master: it drives the operands and receives sum and carry.
interface half_adder_self_checker_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             cout;

    modport master (output a, output b, input s, input cout);
    modport slave  (input a, input b, output s, output cout);
endinterface

// File: rtl/half_adder_self_checker.sv
// Exhaustive stimulus/response engine for a WIDTH-bit half adder.
// Walks every (a,b) pair with b changing fastest, holds each pair for SETTLE
// cycles, then compares the registered {cout,s} against a+b. Reports done/pass,
// a saturating mismatch count and the first failing vector.
module half_adder_self_checker #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    half_adder_self_checker_if.master  bus,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [ERR_W-1:0]           err_count,
    output logic [WIDTH-1:0]           fail_a,
    output logic [WIDTH-1:0]           fail_b,
    output logic [WIDTH-1:0]           fail_s,
    output logic                       fail_cout
);

    localparam int IW = 2 * WIDTH;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [IW-1:0]     idx_q;
    logic [IW-1:0]     idx_d;
    logic [SW-1:0]     settle_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  s_q;
    logic              cout_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [ERR_W-1:0]  err_q;
    logic [ERR_W-1:0]  err_d;
    logic [WIDTH-1:0]  fail_a_q;
    logic [WIDTH-1:0]  fail_b_q;
    logic [WIDTH-1:0]  fail_s_q;
    logic              fail_cout_q;
    logic [WIDTH:0]    exp_sum;
    logic [WIDTH:0]    obs_sum;
    logic              mismatch;
    logic              last_vec;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    // Register the adder response so the compare sees a clean, settled value.
    always_ff @(posedge clk) begin
        s_q    <= bus.s;
        cout_q <= bus.cout;
    end

    // Expected result at full WIDTH+1 precision, next error count and next vector.
    always_comb begin
        exp_sum  = {1'b0, a_q} + {1'b0, b_q};
        obs_sum  = {cout_q, s_q};
        mismatch = (obs_sum != exp_sum);
        err_d    = mismatch ? sat_inc(err_q) : err_q;
        idx_d    = idx_q + IW'(1);
        // Explicit last-vector detect so idx never wraps inside a sweep.
        last_vec = &idx_q;
    end

    // Sweep FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            settle_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            fail_a_q    <= '0;
            fail_b_q    <= '0;
            fail_s_q    <= '0;
            fail_cout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // A start pulse is only honoured here; while busy it is ignored.
                    if (start) begin
                        err_q       <= '0;
                        fail_a_q    <= '0;
                        fail_b_q    <= '0;
                        fail_s_q    <= '0;
                        fail_cout_q <= 1'b0;
                        pass_q      <= 1'b0;
                        idx_q       <= '0;
                        settle_q    <= '0;
                        a_q         <= '0;
                        b_q         <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        state_q     <= DRIVE;
                    end
                end
                DRIVE: begin
                    // Operands are already stable; just let the adder settle.
                    if (settle_q == SETTLE_LAST) begin
                        state_q <= CHECK;
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end
                CHECK: begin
                    err_q <= err_d;
                    // Only the very first mismatch of a sweep is captured.
                    if (mismatch && (err_q == '0)) begin
                        fail_a_q    <= a_q;
                        fail_b_q    <= b_q;
                        fail_s_q    <= s_q;
                        fail_cout_q <= cout_q;
                    end
                    if (last_vec) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                        a_q     <= '0;
                        b_q     <= '0;
                        state_q <= DONE;
                    end else begin
                        idx_q    <= idx_d;
                        a_q      <= idx_d[IW-1:WIDTH];
                        b_q      <= idx_d[WIDTH-1:0];
                        settle_q <= '0;
                        state_q  <= DRIVE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.a     = a_q;
    assign bus.b     = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_a    = fail_a_q;
    assign fail_b    = fail_b_q;
    assign fail_s    = fail_s_q;
    assign fail_cout = fail_cout_q;

endmodule

// File: tb/tb_half_adder_self_checker.sv
// Bench for half_adder_self_checker: three checker instances with different
// WIDTH/SETTLE/ERR_W, each driving a bench-side adder with selectable faults.
module tb_half_adder_self_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rs [3];
    logic st [3];
    int   flt [3];

    half_adder_self_checker_if #(.WIDTH(1)) bus0 ();
    half_adder_self_checker_if #(.WIDTH(2)) bus1 ();
    half_adder_self_checker_if #(.WIDTH(2)) bus2 ();

    logic        busy0, done0, pass0, fc0;
    logic [15:0] e0;
    logic [0:0]  fa0, fb0, fs0;
    logic        busy1, done1, pass1, fc1;
    logic [15:0] e1;
    logic [1:0]  fa1, fb1, fs1;
    logic        busy2, done2, pass2, fc2;
    logic [1:0]  e2;
    logic [1:0]  fa2, fb2, fs2;

    half_adder_self_checker #(.WIDTH(1), .SETTLE(2), .ERR_W(16)) dut0 (
        .clk(clk), .rst(rs[0]), .start(st[0]), .bus(bus0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(e0),
        .fail_a(fa0), .fail_b(fb0), .fail_s(fs0), .fail_cout(fc0));
    half_adder_self_checker #(.WIDTH(2), .SETTLE(1), .ERR_W(16)) dut1 (
        .clk(clk), .rst(rs[1]), .start(st[1]), .bus(bus1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(e1),
        .fail_a(fa1), .fail_b(fb1), .fail_s(fs1), .fail_cout(fc1));
    half_adder_self_checker #(.WIDTH(2), .SETTLE(1), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rs[2]), .start(st[2]), .bus(bus2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(e2),
        .fail_a(fa2), .fail_b(fb2), .fail_s(fs2), .fail_cout(fc2));

    // Instance geometry
    function automatic int pw(input int d); return (d == 0) ? 1 : 2; endfunction
    function automatic int ps(input int d); return (d == 0) ? 2 : 1; endfunction
    function automatic int pe(input int d); return (d == 2) ? 2 : 16; endfunction
    function automatic int swlen(input int d);
        return (1 << (2 * pw(d))) * (ps(d) + 1);
    endfunction

    // Adder with injectable faults: 0 good, 1 cout=0, 2 s[0]=1, 3 s=all-ones,cout=1
    function automatic int adder(input int w, input int f, input int a, input int b);
        int sum, s, c, m;
        m   = (1 << w) - 1;
        sum = a + b;
        s   = sum & m;
        c   = sum >> w;
        if (f == 1) c = 0;
        if (f == 2) s = s | 1;
        if (f == 3) begin s = m; c = 1; end
        return (c << w) | s;
    endfunction

    int r0, r1, r2;
    always_comb r0 = adder(1, flt[0], int'(bus0.a), int'(bus0.b));
    always_comb r1 = adder(2, flt[1], int'(bus1.a), int'(bus1.b));
    always_comb r2 = adder(2, flt[2], int'(bus2.a), int'(bus2.b));
    assign bus0.s = r0[0];   assign bus0.cout = r0[1];
    assign bus1.s = r1[1:0]; assign bus1.cout = r1[2];
    assign bus2.s = r2[1:0]; assign bus2.cout = r2[2];

    int oa [3], ob [3], obusy [3], odone [3], opass [3], oerr [3];
    int ofa [3], ofb [3], ofs [3], ofc [3];
    assign oa[0] = int'(bus0.a);  assign oa[1] = int'(bus1.a);  assign oa[2] = int'(bus2.a);
    assign ob[0] = int'(bus0.b);  assign ob[1] = int'(bus1.b);  assign ob[2] = int'(bus2.b);
    assign obusy[0] = int'(busy0); assign obusy[1] = int'(busy1); assign obusy[2] = int'(busy2);
    assign odone[0] = int'(done0); assign odone[1] = int'(done1); assign odone[2] = int'(done2);
    assign opass[0] = int'(pass0); assign opass[1] = int'(pass1); assign opass[2] = int'(pass2);
    assign oerr[0] = int'(e0);    assign oerr[1] = int'(e1);    assign oerr[2] = int'(e2);
    assign ofa[0] = int'(fa0);    assign ofa[1] = int'(fa1);    assign ofa[2] = int'(fa2);
    assign ofb[0] = int'(fb0);    assign ofb[1] = int'(fb1);    assign ofb[2] = int'(fb2);
    assign ofs[0] = int'(fs0);    assign ofs[1] = int'(fs1);    assign ofs[2] = int'(fs2);
    assign ofc[0] = int'(fc0);    assign ofc[1] = int'(fc1);    assign ofc[2] = int'(fc2);

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int cyc = 0;
    int mode [3] = '{0, 0, 0};   // 0: idle after reset, 1: sweep started at t0
    int t0 [3]   = '{0, 0, 0};
    int flm [3]  = '{0, 0, 0};   // fault in force for the current sweep
    int trace [$];

    task automatic chk(input int d, input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL dut%0d %s cycle %0d: got %0d expected %0d", d, nm, cyc, act, exp);
        end
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model timeline: reset and accepted starts are recorded at each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            for (int d = 0; d < 3; d++) begin
                if (rs[d]) begin
                    mode[d] = 0;
                end else if (st[d] && !(mode[d] == 1 && (cyc - t0[d]) < swlen(d))) begin
                    mode[d] = 1;
                    t0[d]   = cyc + 1;
                    flm[d]  = flt[d];
                end
            end
            cyc++;
        end
    end

    // Expected outputs derived from elapsed time since start and the fault list.
    task automatic check_dut(input int d);
        int w, ln, n, t, idx, nchk, cnt, m, r, va, vb;
        int efa, efb, efs, efc, ea, eb, ebusy, edone, epass, eerr, emax;
        w = pw(d); ln = ps(d) + 1; n = 1 << (2 * w); m = (1 << w) - 1;
        ea = 0; eb = 0; ebusy = 0; edone = 0; nchk = 0;
        if (mode[d] == 1) begin
            t = cyc - t0[d];
            if (t < n * ln) begin
                ebusy = 1;
                idx   = t / ln;
                ea    = idx >> w;
                eb    = idx & m;
                nchk  = t / ln;
            end else begin
                edone = 1;
                nchk  = n;
            end
        end
        cnt = 0; efa = 0; efb = 0; efs = 0; efc = 0;
        for (int v = 0; v < nchk; v++) begin
            va = v >> w;
            vb = v & m;
            r  = adder(w, flm[d], va, vb);
            if (r != va + vb) begin
                if (cnt == 0) begin
                    efa = va; efb = vb; efs = r & m; efc = r >> w;
                end
                cnt++;
            end
        end
        emax  = (1 << pe(d)) - 1;
        eerr  = (cnt > emax) ? emax : cnt;
        epass = (edone == 1 && cnt == 0) ? 1 : 0;
        chk(d, "a", oa[d], ea);
        chk(d, "b", ob[d], eb);
        chk(d, "busy", obusy[d], ebusy);
        chk(d, "done", odone[d], edone);
        chk(d, "pass", opass[d], epass);
        chk(d, "err_count", oerr[d], eerr);
        chk(d, "fail_a", ofa[d], efa);
        chk(d, "fail_b", ofb[d], efb);
        chk(d, "fail_s", ofs[d], efs);
        chk(d, "fail_cout", ofc[d], efc);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int d = 0; d < 3; d++) check_dut(d);
            end
        end
    end

    task automatic pulse(input int d);
        @(posedge clk); #1 st[d] = 1'b1;
        @(posedge clk); #1 st[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, output int nb);
        int k;
        nb = 0; k = 0;
        trace.delete();
        do begin
            @(negedge clk);
            k++;
            if (obusy[d] == 1) begin
                nb++;
                trace.push_back(oa[d] * 4 + ob[d]);
            end
        end while (odone[d] != 1 && k < 2000);
        if (odone[d] != 1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut%0d done_timeout: got done=%0d expected 1", d, odone[d]);
        end
    endtask

    int nb, cs, k, r, g;

    initial begin
        for (int d = 0; d < 3; d++) begin rs[d] = 1'b1; st[d] = 1'b0; flt[d] = 0; end
        @(posedge clk); #1 chk_en = 1'b1;
        @(posedge clk); #1 for (int d = 0; d < 3; d++) rs[d] = 1'b0;
        @(negedge clk);
        lit("reset_busy", obusy[0], 0);
        lit("reset_err", oerr[1], 0);

        // 1: clean W=1 sweep
        flt[0] = 0;
        pulse(0);
        wait_done(0, nb);
        lit("t1_busy_cycles", nb, 12);
        if (trace.size() == 12) begin
            lit("t1_vec0", trace[0], 0);
            lit("t1_vec1", trace[3], 1);
            lit("t1_vec2", trace[6], 4);
            lit("t1_vec3", trace[9], 5);
        end else begin
            lit("t1_trace_len", trace.size(), 12);
        end
        lit("t1_pass", opass[0], 1);
        lit("t1_err", oerr[0], 0);

        // 2: cout forced low
        flt[0] = 1;
        pulse(0);
        wait_done(0, nb);
        lit("t2_err", oerr[0], 1);
        lit("t2_pass", opass[0], 0);
        lit("t2_fail_a", ofa[0], 1);
        lit("t2_fail_b", ofb[0], 1);
        lit("t2_fail_s", ofs[0], 0);
        lit("t2_fail_cout", ofc[0], 0);

        // 3: W=2, s[0] stuck at 1
        flt[1] = 2;
        pulse(1);
        wait_done(1, nb);
        lit("t3_busy_cycles", nb, 32);
        lit("t3_err", oerr[1], 8);
        lit("t3_fail_a", ofa[1], 0);
        lit("t3_fail_b", ofb[1], 0);
        lit("t3_fail_s", ofs[1], 1);
        lit("t3_fail_cout", ofc[1], 0);

        // 4: start re-pulsed on cycle 3 is ignored
        flt[0] = 0;
        pulse(0);
        cs = cyc;
        @(posedge clk);
        pulse(0);
        wait_done(0, nb);
        lit("t4_sweep_len", cyc - cs, 12);
        lit("t4_pass", opass[0], 1);

        // 5: reset while idx=2, then a clean sweep
        flt[0] = 3;
        pulse(0);
        k = 0;
        do begin @(negedge clk); k++; end while (!(obusy[0] == 1 && oa[0] == 1 && ob[0] == 0) && k < 100);
        lit("t5_reached_idx2", oa[0] * 2 + ob[0], 2);
        rs[0] = 1'b1;
        @(posedge clk); #1 rs[0] = 1'b0;
        @(negedge clk);
        lit("t5_busy", obusy[0], 0);
        lit("t5_done", odone[0], 0);
        lit("t5_err", oerr[0], 0);
        flt[0] = 0;
        pulse(0);
        wait_done(0, nb);
        lit("t5_clean_pass", opass[0], 1);

        // 6: every vector fails, ERR_W=2 saturates
        flt[2] = 3;
        pulse(2);
        wait_done(2, nb);
        lit("t6_err_sat", oerr[2], 3);
        lit("t6_fail_a", ofa[2], 0);
        lit("t6_fail_b", ofb[2], 0);
        lit("t6_fail_s", ofs[2], 3);
        lit("t6_fail_cout", ofc[2], 1);
        lit("t6_pass", opass[2], 0);
        pulse(2);
        @(negedge clk);
        lit("t6_restart_err", oerr[2], 0);
        lit("t6_restart_done", odone[2], 0);
        wait_done(2, nb);
        lit("t6_again_err", oerr[2], 3);

        // Randomized sweeps with stray starts and reset/start collisions
        for (int i = 0; i < 14; i++) begin
            g = $urandom_range(0, 2);
            flt[g] = $urandom_range(0, 3);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            pulse(g);
            r = $urandom_range(0, 3);
            if (r == 0) begin
                repeat ($urandom_range(0, 6)) @(posedge clk);
                pulse(g);
                wait_done(g, nb);
            end else if (r == 1) begin
                repeat ($urandom_range(0, 8)) @(posedge clk);
                #1 st[g] = 1'b1; rs[g] = 1'b1;
                @(posedge clk); #1 st[g] = 1'b0; rs[g] = 1'b0;
                @(negedge clk);
                lit("rand_rst_wins_busy", obusy[g], 0);
            end else begin
                wait_done(g, nb);
                lit("rand_busy_cycles", nb, swlen(g));
            end
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/half_adder_self_checker.md
Name: half_adder_self_checker

Overview:
- Synthesizable stimulus/response engine for the parameterized half adder.
- Drives the adder's a/b inputs with every operand combination, samples s/cout, and compares them against a+b.
- Reports done, pass/fail, a saturating error count, and the first failing vector.
- Used for on-board self-test and as the hardware counterpart of the adder benches.

Parameters:
- WIDTH, 1, operand width; must match the adder instance (WIDTH >= 1).
- SETTLE, 2, cycles each vector is held before sampling (SETTLE >= 1).
- ERR_W, 16, width of err_count.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a sweep; honoured in IDLE or DONE only.
- a  output  WIDTH  operand A to adder.
- b  output  WIDTH  operand B to adder.
- s  input  WIDTH  adder sum.
- cout  input  1  adder carry.
- busy  output  1  high while a sweep is running.
- done  output  1  high from sweep completion until the next start or rst.
- pass  output  1  valid when done=1; 1 if zero mismatches.
- err_count  output  ERR_W  mismatch count; saturates at all-ones.
- fail_a  output  WIDTH  A of the first mismatching vector.
- fail_b  output  WIDTH  B of the first mismatching vector.
- fail_s  output  WIDTH  s observed at the first mismatch.
- fail_cout  output  1  cout observed at the first mismatch.

Behaviour:
- Reset values: a=b=0, busy=0, done=0, pass=0, err_count=0, all fail_* = 0; FSM in IDLE; vector index=0; settle counter=0.
- Vector index idx is 2*WIDTH bits wide; a = idx[2W-1:W], b = idx[W-1:0]. Vectors run 0..2^(2W)-1, so b changes fastest. For W=1 the order is (a,b) = 00, 01, 10, 11.
- Expected value: {cout,s} == a + b, computed at WIDTH+1 bits with no truncation.

FSM states:
- IDLE: a=b=0. On start:
  - clear err_count, all fail_* and pass;
  - idx=0, settle=0;
  - busy=1;
  - go to DRIVE.
- DRIVE: a/b are registered from idx and stable throughout the state. Settle counter increments each cycle. After SETTLE cycles in DRIVE, go to CHECK.
- CHECK (one cycle): compare the registered s/cout against expected.
  - On mismatch: increment err_count (saturating).
  - If this is the first mismatch (err_count was 0): capture a, b, s, cout into the fail_* outputs.
  - If idx is the last vector: go to DONE. Otherwise: idx+1, settle=0, go to DRIVE.
- DONE:
  - Register behaviour: busy=0, done=1, pass = (err_count==0), a=b=0.
  - On start: same actions as start in IDLE (done drops the next cycle).

Timing:
- Each vector takes SETTLE+1 cycles.
- A sweep takes 2^(2W)*(SETTLE+1) cycles from the cycle after start to busy falling.
- done rises on the same edge busy falls.

Boundary conditions:
- start while busy=1: ignored; the sweep is not restarted.
- start and rst in the same cycle: rst wins.
- rst mid-sweep: returns to reset values on the next edge. No partial results are retained.
- err_count saturation: stays at 2^ERR_W-1; the fail_* outputs are never overwritten after the first capture.
- idx wrap: the last vector is detected explicitly, so idx never wraps to 0 inside a sweep.
- pass is 0 whenever done=0.

Test Plan:
1. WIDTH=1, SETTLE=2, correct adder, start pulse.
   - Required: a/b step 00, 01, 10, 11.
   - busy high for 12 cycles.
   - Then done=1, pass=1, err_count=0.
2. WIDTH=1, adder model with cout forced 0.
   - Required: only vector 11 fails; err_count=1, pass=0.
   - fail_a=1, fail_b=1, fail_s=0, fail_cout=0.
3. WIDTH=2, SETTLE=1, sum bit0 stuck-at-1.
   - Required: 16 vectors in 32 cycles.
   - err_count=8 (the cases where a+b is even).
   - First failure captured as fail_a=0, fail_b=0, fail_s=1, fail_cout=0.
4. Start pulse re-asserted on cycle 3 of a sweep.
   - Required: ignored; the sweep completes on its original schedule.
5. rst asserted while idx=2.
   - Required: next cycle busy=0, done=0, a=b=0, err_count=0.
   - A subsequent start runs a full clean sweep.
6. ERR_W=2, WIDTH=2, s tied to all-ones and cout tied to 1 (every vector fails).
   - Required: err_count saturates at 3.
   - fail_* hold the values from vector (0,0); pass=0.
   - A second start clears the results and repeats the sweep.
